sbus_nport: RTL and testbench
=============================

SBUS_NPORT -- requirements
Module: sbus_nport

Interface
REQ-001 SHALL have parameter NUM_M, default 3: number of master ports, range 2..8.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have parameter BCW, default 4: burst-count width.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  system clock, rising edge; rst_i  in  1  asynchronous active-high reset.
REQ-007 m_dat_i  in  NUM_M*DW  per-master write data; master k occupies bits [k*DW +: DW].
REQ-008 m_adr_i  in  NUM_M*AW  per-master address.
REQ-009 m_stb_i  in  NUM_M  per-master request strobe.
REQ-010 m_we_i  in  NUM_M  per-master write enable, 1 = write.
REQ-011 m_sel_i  in  NUM_M*4  per-master byte selects.
REQ-012 m_burst_cnt_i  in  NUM_M*BCW  per-master beat count.
REQ-013 m_dat_o  out  DW  read data, shared by all masters.
REQ-014 m_ack_o  out  NUM_M  per-master beat acknowledge.
REQ-015 wrp_dat_i  in  DW  read data from the AHB master wrapper.
REQ-016 wrp_ack_i  in  1  beat acknowledge from the wrapper.
REQ-017 wrp_ack_bus_i  in  1  wrapper has released the AHB bus.
REQ-018 wrp_dat_o / wrp_adr_o / wrp_we_o / wrp_sel_o / wrp_burst_cnt_o  out  DW/AW/1/4/BCW  granted master's request fields.
REQ-019 wrp_stb_o  out  1  request strobe to the wrapper.
REQ-020 grant_o  out  NUM_M  one-hot grant vector, 0 when idle.
REQ-021 busy_o  out  1  1 in any state other than IDLE.

Function
REQ-022 FSM SHALL have exactly three states: IDLE, XFER, RELEASE.
REQ-023 IDLE: if any m_stb_i bit is 1, SHALL select a winner per ARB_MODE, register the winner's index and burst count, and enter XFER on the next edge.
REQ-024 Round-robin: search SHALL start at (last_grant+1) mod NUM_M and wrap; last_grant SHALL update only on grant.
REQ-025 A latched burst count of 0 SHALL be treated as 1.
REQ-026 XFER: wrp_stb_o SHALL be 1, and the wrp_* request outputs SHALL carry the granted master's dat/adr/we/sel/burst_cnt, combinationally muxed from the registered index.
REQ-027 XFER: m_ack_o[g] SHALL equal wrp_ack_i (combinational), other ack bits SHALL be 0, and m_dat_o SHALL equal wrp_dat_i.
REQ-028 Beat counter SHALL increment on each wrp_ack_i in XFER; on the ack that reaches the latched count, the FSM SHALL enter RELEASE on the next edge.
REQ-029 RELEASE: wrp_stb_o SHALL be 0, all m_ack_o bits SHALL be 0, and grant_o SHALL stay asserted.
REQ-030 RELEASE SHALL go to IDLE on the edge where wrp_ack_bus_i=1.
REQ-031 If wrp_ack_bus_i was 1 concurrent with the final wrp_ack_i, RELEASE SHALL last exactly 1 cycle.
REQ-032 Latency: stb rising in IDLE -> wrp_stb_o=1 on the next cycle; no new grant earlier than 1 cycle after entering IDLE (minimum 1 IDLE cycle between transfers).
REQ-033 During XFER/RELEASE, changes on any m_stb_i (including the granted master dropping stb) SHALL be ignored; the transfer always completes.
REQ-034 wrp_ack_i outside XFER SHALL be ignored.
REQ-035 m_dat_o SHALL be 0 outside XFER.
REQ-036 The beat counter SHALL be BCW bits wide and SHALL never wrap within a transfer.

Reset
REQ-037 rst_i=1 SHALL asynchronously force state IDLE, beat counter 0, grant index 0, last_grant NUM_M-1 (so the first round-robin search starts at 0), and wrp_stb_o, grant_o, busy_o, m_ack_o all 0.
REQ-038 Reset asserted mid-XFER SHALL abort the transfer with no ack issued after reset assertion.

Verification
REQ-039 ARB_MODE=0, m_stb_i=3'b110 held, single beats, wrapper acks -> grants SHALL be master 1 repeatedly and master 2 never, until master 1 drops stb.
REQ-040 ARB_MODE=1, m_stb_i=3'b111 held, single beats -> grant order SHALL be 0,1,2,0,... with one IDLE cycle between each.
REQ-041 Master 0 burst_cnt=4, acks on cycles 2,3,5,6 of XFER -> exactly 4 m_ack_o[0] pulses, wrp_stb_o=0 the cycle after the 4th ack.
REQ-042 burst_cnt=0 -> exactly 1 beat; wrp_ack_bus_i delayed 3 cycles -> RELEASE SHALL last 3 cycles with busy_o=1.
REQ-043 rst_i pulsed during beat 2 of a 4-beat burst -> all outputs 0 immediately; the next request SHALL be granted normally from IDLE.

Source files
------------

// File: rtl/sbus_nport.sv
`default_nettype none
// ============================================================================
// Module   : sbus_nport
// Purpose  : N-master shared-bus arbiter and request mux in front of one
//            AHB master wrapper (fixed-priority or round-robin).
// Revision : 1.0  initial release
// ============================================================================
module sbus_nport #(
  parameter int NUM_M    = 3,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int BCW      = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master side
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  input  logic [NUM_M*AW-1:0]   m_adr_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*4-1:0]    m_sel_i,
  input  logic [NUM_M*BCW-1:0]  m_burst_cnt_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  // wrapper side
  input  logic [DW-1:0]         wrp_dat_i,
  input  logic                  wrp_ack_i,
  input  logic                  wrp_ack_bus_i,
  output logic [DW-1:0]         wrp_dat_o,
  output logic [AW-1:0]         wrp_adr_o,
  output logic                  wrp_we_o,
  output logic [3:0]            wrp_sel_o,
  output logic [BCW-1:0]        wrp_burst_cnt_o,
  output logic                  wrp_stb_o,
  // status
  output logic [NUM_M-1:0]      grant_o,
  output logic                  busy_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0]     c_st_idle    = 2'd0;
  localparam logic [1:0]     c_st_xfer    = 2'd1;
  localparam logic [1:0]     c_st_release = 2'd2;
  localparam logic [IW-1:0]  c_last_rst   = IW'(NUM_M - 1);
  localparam logic [BCW-1:0] c_one        = BCW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_last;
  logic [BCW-1:0]   r_cnt;
  logic [BCW-1:0]   r_beat;
  logic             r_bus_early;

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [BCW-1:0]   w_win_bc;
  logic             w_final;
  logic [NUM_M-1:0] w_gvec;

  assign w_any   = |m_stb_i;
  assign w_final = (r_state == c_st_xfer) && wrp_ack_i && (r_beat == (r_cnt - c_one));

  // Fixed priority is a circular search that always starts at index 0.
  always_comb begin
    int   w_base;
    int   w_idx;
    logic w_found;
    w_base  = (ARB_MODE == 1) ? ((int'(r_last) + 1) % NUM_M) : 0;
    w_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_idx = w_base + i;
      if (w_idx >= NUM_M) w_idx = w_idx - NUM_M;
      for (int k = 0; k < NUM_M; k++) begin
        if (!w_found && (k == w_idx) && m_stb_i[k]) begin
          w_win   = IW'(k);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_win_bc = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_win == IW'(k)) w_win_bc = m_burst_cnt_i[k*BCW +: BCW];
    end
  end

  always_comb begin
    w_gvec          = '0;
    wrp_dat_o       = '0;
    wrp_adr_o       = '0;
    wrp_we_o        = 1'b0;
    wrp_sel_o       = '0;
    wrp_burst_cnt_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (r_gidx == IW'(k)) begin
        w_gvec[k]       = 1'b1;
        wrp_dat_o       = m_dat_i[k*DW +: DW];
        wrp_adr_o       = m_adr_i[k*AW +: AW];
        wrp_we_o        = m_we_i[k];
        wrp_sel_o       = m_sel_i[k*4 +: 4];
        wrp_burst_cnt_o = m_burst_cnt_i[k*BCW +: BCW];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_st_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:    if (w_any) w_next = c_st_xfer;
      c_st_xfer:    if (w_final) w_next = c_st_release;
      c_st_release: if (wrp_ack_bus_i || r_bus_early) w_next = c_st_idle;
      default:      w_next = c_st_idle;
    endcase
  end

  always_comb begin
    wrp_stb_o = 1'b0;
    busy_o    = 1'b0;
    grant_o   = '0;
    m_ack_o   = '0;
    m_dat_o   = '0;
    case (r_state)
      c_st_xfer: begin
        wrp_stb_o = 1'b1;
        busy_o    = 1'b1;
        grant_o   = w_gvec;
        m_ack_o   = wrp_ack_i ? w_gvec : '0;
        m_dat_o   = wrp_dat_i;
      end
      c_st_release: begin
        busy_o  = 1'b1;
        grant_o = w_gvec;
      end
      default: ;
    endcase
  end

  // A bus release seen together with the last beat lets RELEASE finish unconditionally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gidx      <= '0;
      r_last      <= c_last_rst;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_bus_early <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_bus_early <= 1'b0;
          if (w_any) begin
            r_gidx <= w_win;
            r_last <= w_win;
            r_cnt  <= (w_win_bc == '0) ? c_one : w_win_bc;
            r_beat <= '0;
          end
        end
        c_st_xfer: begin
          if (wrp_ack_i) begin
            r_beat <= r_beat + c_one;
            if (w_final) r_bus_early <= wrp_ack_bus_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbus_nport.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbus_nport
// Purpose  : Self-checking bench for sbus_nport, fixed and round-robin modes.
// Revision : 1.0  initial release
// ============================================================================
module tb_sbus_nport;

  localparam int NM  = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BCW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM*DW-1:0]  m_dat;
  logic [NM*AW-1:0]  m_adr;
  logic [NM-1:0]     m_stb;
  logic [NM-1:0]     m_we;
  logic [NM*4-1:0]   m_sel;
  logic [NM*BCW-1:0] m_bc;

  logic [DW-1:0]  wdat [2];
  logic           wack [2];
  logic           wbus [2];

  logic [DW-1:0]  m_dat_o   [2];
  logic [NM-1:0]  m_ack_o   [2];
  logic [DW-1:0]  wrp_dat_o [2];
  logic [AW-1:0]  wrp_adr_o [2];
  logic           wrp_we_o  [2];
  logic [3:0]     wrp_sel_o [2];
  logic [BCW-1:0] wrp_bc_o  [2];
  logic           wrp_stb_o [2];
  logic [NM-1:0]  grant_o   [2];
  logic           busy_o    [2];

  // Instance 0 is fixed priority, instance 1 is round-robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sbus_nport #(.NUM_M(NM), .DW(DW), .AW(AW), .BCW(BCW), .ARB_MODE(g)) u_dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .m_dat_i         (m_dat),
      .m_adr_i         (m_adr),
      .m_stb_i         (m_stb),
      .m_we_i          (m_we),
      .m_sel_i         (m_sel),
      .m_burst_cnt_i   (m_bc),
      .m_dat_o         (m_dat_o[g]),
      .m_ack_o         (m_ack_o[g]),
      .wrp_dat_i       (wdat[g]),
      .wrp_ack_i       (wack[g]),
      .wrp_ack_bus_i   (wbus[g]),
      .wrp_dat_o       (wrp_dat_o[g]),
      .wrp_adr_o       (wrp_adr_o[g]),
      .wrp_we_o        (wrp_we_o[g]),
      .wrp_sel_o       (wrp_sel_o[g]),
      .wrp_burst_cnt_o (wrp_bc_o[g]),
      .wrp_stb_o       (wrp_stb_o[g]),
      .grant_o         (grant_o[g]),
      .busy_o          (busy_o[g])
    );
  end

  // Transaction-level reference: who owns the bus, beats still owed, release pending.
  int            owner [2];
  int            left  [2];
  int            last  [2];
  bit            fast  [2];
  logic [NM-1:0] prev_g [2];
  int            gq0 [$];
  int            gq1 [$];
  int            n_chk  = 0;
  int            n_pass = 0;

  typedef struct {
    logic [NM-1:0] stb;
    logic [NM-1:0] g0;
    logic [NM-1:0] g1;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s dut%0d: actual=%0h expected=%0h", nm, d, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d]  = -1;
      left[d]   = 0;
      last[d]   = NM - 1;
      fast[d]   = 1'b0;
      prev_g[d] = '0;
    end
  endtask

  function automatic int pick(input int d, input logic [NM-1:0] s);
    if (d == 0) begin
      for (int k = 0; k < NM; k++) if (s[k]) return k;
    end else begin
      for (int j = 1; j <= NM; j++) if (s[(last[d] + j) % NM]) return (last[d] + j) % NM;
    end
    return -1;
  endfunction

  task automatic model_update(input int d);
    int bc;
    if (owner[d] < 0) begin
      if (m_stb != '0) begin
        owner[d] = pick(d, m_stb);
        bc       = int'(m_bc[owner[d]*BCW +: BCW]);
        left[d]  = (bc == 0) ? 1 : bc;
        last[d]  = owner[d];
      end
    end else if (left[d] > 0) begin
      if (wack[d]) begin
        left[d]--;
        if (left[d] == 0) fast[d] = wbus[d];
      end
    end else if (wbus[d] || fast[d]) begin
      owner[d] = -1;
      fast[d]  = 1'b0;
    end
  endtask

  task automatic check_dut(input int d);
    logic [NM-1:0] g_e;
    logic [NM-1:0] a_e;
    logic          x;
    int            o;
    o   = owner[d];
    x   = (o >= 0) && (left[d] > 0);
    g_e = '0;
    a_e = '0;
    if (o >= 0) g_e[o] = 1'b1;
    if (x && wack[d]) a_e[o] = 1'b1;
    chk("busy", d, busy_o[d], o >= 0);
    chk("wrp_stb", d, wrp_stb_o[d], x);
    chk("grant", d, grant_o[d], g_e);
    chk("m_ack", d, m_ack_o[d], a_e);
    chk("m_dat", d, m_dat_o[d], x ? wdat[d] : '0);
    if (x) begin
      chk("wrp_dat", d, wrp_dat_o[d], m_dat[o*DW +: DW]);
      chk("wrp_adr", d, wrp_adr_o[d], m_adr[o*AW +: AW]);
      chk("wrp_we", d, wrp_we_o[d], m_we[o]);
      chk("wrp_sel", d, wrp_sel_o[d], m_sel[o*4 +: 4]);
      chk("wrp_bc", d, wrp_bc_o[d], m_bc[o*BCW +: BCW]);
    end
    if (grant_o[d] != '0 && prev_g[d] == '0) begin
      for (int k = 0; k < NM; k++) begin
        if (grant_o[d][k]) begin
          if (d == 0) gq0.push_back(k);
          else        gq1.push_back(k);
        end
      end
    end
    prev_g[d] = grant_o[d];
  endtask

  // Inputs are set right after a falling edge; outputs checked 1 ns later.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d);
    @(negedge clk);
  endtask

  task automatic set_quiet();
    m_stb = '0;
    m_bc  = '0;
    for (int d = 0; d < 2; d++) begin
      wack[d] = 1'b0;
      wbus[d] = 1'b0;
      wdat[d] = 32'hD0D0_0000 + DW'(d);
    end
  endtask

  task automatic set_wrp(input logic a, input logic b);
    for (int d = 0; d < 2; d++) begin
      wack[d] = a;
      wbus[d] = b;
    end
  endtask

  task automatic do_reset();
    set_quiet();
    set_wrp(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, busy_o[d], 1'b0);
      chk("rst_grant", d, grant_o[d], '0);
      chk("rst_stb", d, wrp_stb_o[d], 1'b0);
      chk("rst_ack", d, m_ack_o[d], '0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_wrp(1'b0, 1'b0);
    gq0.delete();
    gq1.delete();
  endtask

  initial begin
    int pulses;
    m_dat = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    m_adr = {32'hC000_0300, 32'hB000_0200, 32'hA000_0100};
    m_we  = 3'b101;
    m_sel = 12'hA5C;
    set_quiet();
    model_reset();

    tbl[0] = '{stb: 3'b111, g0: 3'b001, g1: 3'b001};
    tbl[1] = '{stb: 3'b111, g0: 3'b001, g1: 3'b010};
    tbl[2] = '{stb: 3'b101, g0: 3'b001, g1: 3'b100};
    tbl[3] = '{stb: 3'b110, g0: 3'b010, g1: 3'b010};
    tbl[4] = '{stb: 3'b011, g0: 3'b001, g1: 3'b001};
    tbl[5] = '{stb: 3'b100, g0: 3'b100, g1: 3'b100};
    tbl[6] = '{stb: 3'b011, g0: 3'b001, g1: 3'b001};
    tbl[7] = '{stb: 3'b010, g0: 3'b010, g1: 3'b010};

    // Table: single-beat transfers, both instances in lockstep
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_stb = tbl[i].stb;
      step();
      m_stb = '0;
      set_wrp(1'b1, 1'b1);
      #1;
      chk("tbl_grant", 0, grant_o[0], tbl[i].g0);
      chk("tbl_grant", 1, grant_o[1], tbl[i].g1);
      step();
      set_wrp(1'b0, 1'b0);
      step();
      step();
    end

    // Fixed priority starves master 2 while master 1 holds its strobe
    do_reset();
    m_stb = 3'b110;
    set_wrp(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step();
    chk("fix_cnt", 0, gq0.size(), 4);
    for (int i = 0; i < gq0.size(); i++) chk("fix_order", 0, gq0[i], 1);
    gq0.delete();
    m_stb = 3'b100;
    for (int i = 0; i < 3; i++) step();
    chk("fix_m2", 0, (gq0.size() > 0) ? gq0[0] : -1, 2);

    // Round-robin rotation with all strobes held
    do_reset();
    m_stb = 3'b111;
    set_wrp(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step();
    chk("rr_cnt", 1, gq1.size(), 4);
    for (int i = 0; i < gq1.size() && i < 4; i++) chk("rr_order", 1, gq1[i], i % 3);

    // 4-beat burst, acks on XFER cycles 2,3,5,6
    do_reset();
    m_stb = 3'b001;
    m_bc  = 12'h004;
    step();
    m_stb  = '0;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      set_wrp((c == 2) || (c == 3) || (c == 5) || (c == 6), 1'b0);
      #1;
      if (m_ack_o[0][0]) pulses++;
      step();
    end
    set_wrp(1'b0, 1'b1);
    #1;
    chk("burst_pulses", 0, pulses, 4);
    chk("burst_stb_off", 0, wrp_stb_o[0], 1'b0);
    step();
    set_wrp(1'b0, 1'b0);
    step();

    // Zero burst count is one beat; bus release arrives on the third RELEASE cycle
    do_reset();
    m_stb = 3'b100;
    m_bc  = 12'h000;
    step();
    m_stb = '0;
    set_wrp(1'b1, 1'b0);
    step();
    for (int r = 0; r < 3; r++) begin
      set_wrp(1'b1, r == 2);
      #1;
      chk("rel_busy", 0, busy_o[0], 1'b1);
      chk("rel_stb", 0, wrp_stb_o[0], 1'b0);
      step();
    end
    set_wrp(1'b0, 1'b0);
    #1;
    chk("rel_done", 0, busy_o[0], 1'b0);
    step();

    // Asynchronous reset during beat 2 of a 4-beat burst
    do_reset();
    m_stb = 3'b001;
    m_bc  = 12'h004;
    step();
    set_wrp(1'b1, 1'b0);
    step();
    #1;
    chk("pre_rst_ack", 0, m_ack_o[0], 3'b001);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_ack", d, m_ack_o[d], '0);
      chk("abort_grant", d, grant_o[d], '0);
      chk("abort_busy", d, busy_o[d], 1'b0);
      chk("abort_stb", d, wrp_stb_o[d], 1'b0);
      chk("abort_dat", d, m_dat_o[d], '0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_stb = 3'b010;
    m_bc  = 12'h010;
    set_wrp(1'b0, 1'b0);
    step();
    m_stb = '0;
    set_wrp(1'b1, 1'b1);
    #1;
    chk("post_rst_grant", 0, grant_o[0], 3'b010);
    step();
    set_wrp(1'b0, 1'b0);
    step();
    step();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      m_stb = NM'($urandom_range(0, 7));
      for (int k = 0; k < NM; k++) m_bc[k*BCW +: BCW] = BCW'($urandom_range(0, 3));
      m_dat = {$urandom(), $urandom(), $urandom()};
      m_adr = {$urandom(), $urandom(), $urandom()};
      m_we  = NM'($urandom());
      m_sel = 12'($urandom());
      for (int d = 0; d < 2; d++) begin
        wdat[d] = $urandom();
        wack[d] = ($urandom_range(0, 1) == 1);
        wbus[d] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
